tlu_rx: RTL and testbench

- DUT-side end of the TLU trigger/handshake link.
- Detects a trigger pulse on TLU_TRIGGER and asserts TLU_BUSY in response.
- Once the line drops, generates N_BITS_TRIGGER_ID TLU_CLOCK pulses and shifts in the trigger ID LSB-first from TLU_TRIGGER.
- Presents the ID on a valid/ready interface to the DUT readout, keeping TLU_BUSY asserted until the ID is consumed.

---
 rtl/tlu_rx.sv | 159 +++++++++++++++
 tb/tb_tlu_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlu_rx.sv
// tlu_rx: DUT-side receiver for the TLU trigger / busy / clock handshake.
// Filters a trigger, clocks the trigger ID in LSB-first and hands it off.
module tlu_rx #(
  parameter bit          INV_IO       = 1'b0,
  parameter int unsigned CLK_HALF     = 8,
  parameter int unsigned MIN_TRIG_LEN = 2,
  parameter int unsigned HS_TIMEOUT   = 1024,
  parameter int unsigned HOLDOFF      = 4
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RST_N,
  input  logic        ENABLE,
  input  logic [4:0]  N_BITS_TRIGGER_ID,
  input  logic        TLU_TRIGGER,
  output logic        TLU_BUSY,
  output logic        TLU_CLOCK,
  output logic [30:0] TRIG_ID,
  output logic        TRIG_ID_VALID,
  input  logic        TRIG_ID_READY,
  output logic        TRIG_ACCEPTED,
  output logic        HS_ERROR,
  output logic [31:0] TRIG_CNT
);
  typedef enum logic [2:0] {
    IDLE, HANDSHAKE, CLK_HIGH, CLK_LOW, OUTPUT, RELEASE
  } state_t;

  localparam logic [7:0]  HALF_LAST = 8'(CLK_HALF - 1);
  localparam logic [3:0]  FLT_LEN   = 4'(MIN_TRIG_LEN);
  localparam logic [31:0] TO_LAST   = 32'(HS_TIMEOUT - 1);
  localparam logic [31:0] HOLD_LD   = 32'(HOLDOFF);

  state_t      state;
  logic        sync1;
  logic        trig_s;
  logic        busy;
  logic        tclk;
  logic [3:0]  flt;
  logic [7:0]  cnt;
  logic [31:0] tmo;
  logic [31:0] hold;
  logic [4:0]  n;
  logic [4:0]  k;
  logic [30:0] sh;
  logic [30:0] sh_upd;
  logic        hit;

  assign hit = trig_s && ENABLE &&
               (({1'b0, flt} + 5'd1) >= {1'b0, FLT_LEN});

  always_comb begin
    sh_upd    = sh;
    sh_upd[k] = trig_s;
  end

  assign TLU_BUSY  = busy ^ INV_IO;
  assign TLU_CLOCK = tclk ^ INV_IO;

  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RST_N) begin
      state         <= IDLE;
      sync1         <= 1'b0;
      trig_s        <= 1'b0;
      busy          <= 1'b0;
      tclk          <= 1'b0;
      flt           <= '0;
      cnt           <= '0;
      tmo           <= '0;
      hold          <= '0;
      n             <= '0;
      k             <= '0;
      sh            <= '0;
      TRIG_ID       <= '0;
      TRIG_ID_VALID <= 1'b0;
      TRIG_ACCEPTED <= 1'b0;
      HS_ERROR      <= 1'b0;
      TRIG_CNT      <= '0;
    end else begin
      sync1         <= TLU_TRIGGER ^ INV_IO;
      trig_s        <= sync1;
      TRIG_ACCEPTED <= 1'b0;
      HS_ERROR      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hold != 32'd0) hold <= hold - 32'd1;
          if (!(trig_s && ENABLE)) flt <= '0;
          else if (flt < FLT_LEN) flt <= flt + 4'd1;
          if (hit && hold == 32'd0) begin
            n             <= N_BITS_TRIGGER_ID;
            sh            <= '0;
            TRIG_ACCEPTED <= 1'b1;
            TRIG_CNT      <= TRIG_CNT + 32'd1;
            busy          <= 1'b1;
            flt           <= '0;
            cnt           <= '0;
            tmo           <= '0;
            state         <= HANDSHAKE;
          end
        end
        HANDSHAKE: begin
          tmo <= tmo + 32'd1;
          cnt <= trig_s ? 8'd0 : cnt + 8'd1;
          if (!trig_s && cnt == HALF_LAST) begin
            cnt <= '0;
            k   <= '0;
            if (n == 5'd0) begin
              TRIG_ID       <= '0;
              TRIG_ID_VALID <= 1'b1;
              state         <= OUTPUT;
            end else begin
              tclk  <= 1'b1;
              state <= CLK_HIGH;
            end
          end else if (tmo == TO_LAST) begin
            HS_ERROR <= 1'b1;
            busy     <= 1'b0;
            state    <= RELEASE;
          end
        end
        CLK_HIGH: begin
          cnt <= cnt + 8'd1;
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            tclk  <= 1'b0;
            state <= CLK_LOW;
          end
        end
        CLK_LOW: begin
          cnt <= cnt + 8'd1;
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            sh  <= sh_upd;
            if (k == n - 5'd1) begin
              TRIG_ID       <= sh_upd;
              TRIG_ID_VALID <= 1'b1;
              state         <= OUTPUT;
            end else begin
              k     <= k + 5'd1;
              tclk  <= 1'b1;
              state <= CLK_HIGH;
            end
          end
        end
        OUTPUT: begin
          if (TRIG_ID_READY) begin
            TRIG_ID_VALID <= 1'b0;
            busy          <= 1'b0;
            state         <= RELEASE;
          end
        end
        RELEASE: begin
          hold  <= HOLD_LD;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tlu_rx.sv
// tb_tlu_rx: randomized TLU emulator driving tlu_rx, checked against
// a transaction-level model; an inverted-IO twin is compared pin for pin.
module tb_tlu_rx;
  localparam int CH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [4:0]  nbits;
  logic        trig;
  logic        ready;
  logic        busy, tclk, valid, acc, err;
  logic [30:0] id;
  logic [31:0] tcnt;
  logic        busy_i, tclk_i, valid_i, acc_i, err_i;
  logic [30:0] id_i;
  logic [31:0] tcnt_i;
  logic        trig_n;

  int nchk = 0;
  int nerr = 0;
  int rise_cnt = 0, bad_hi = 0, bad_lo = 0, acc_cnt = 0, err_cnt = 0;
  int vld_cyc = 0, busy_fall = 0, busy_cyc = 0, eq_bad = 0;
  int hi_len = 0, lo_len = 0;
  bit first = 1'b1, eq_on = 1'b0;
  logic tclk_q = 1'b0, busy_q = 1'b0;
  logic [31:0] exp_cnt = 0;

  assign trig_n = ~trig;

  always #5 clk = ~clk;

  tlu_rx dut (
    .SYS_CLK(clk), .SYS_RST_N(rst_n), .ENABLE(enable),
    .N_BITS_TRIGGER_ID(nbits), .TLU_TRIGGER(trig),
    .TLU_BUSY(busy), .TLU_CLOCK(tclk), .TRIG_ID(id),
    .TRIG_ID_VALID(valid), .TRIG_ID_READY(ready),
    .TRIG_ACCEPTED(acc), .HS_ERROR(err), .TRIG_CNT(tcnt)
  );

  tlu_rx #(.INV_IO(1'b1)) dut_inv (
    .SYS_CLK(clk), .SYS_RST_N(rst_n), .ENABLE(enable),
    .N_BITS_TRIGGER_ID(nbits), .TLU_TRIGGER(trig_n),
    .TLU_BUSY(busy_i), .TLU_CLOCK(tclk_i), .TRIG_ID(id_i),
    .TRIG_ID_VALID(valid_i), .TRIG_ID_READY(ready),
    .TRIG_ACCEPTED(acc_i), .HS_ERROR(err_i), .TRIG_CNT(tcnt_i)
  );

  always @(negedge clk) begin
    if (acc) begin acc_cnt++; first = 1'b1; end
    if (err) err_cnt++;
    if (valid) vld_cyc++;
    if (busy) busy_cyc++;
    if (busy_q && !busy) busy_fall++;
    if (tclk && !tclk_q) begin
      rise_cnt++;
      if (!first && lo_len != CH) bad_lo++;
      first = 1'b0;
    end
    if (!tclk && tclk_q && hi_len != CH) bad_hi++;
    hi_len = tclk ? hi_len + 1 : 0;
    lo_len = tclk ? 0 : lo_len + 1;
    tclk_q = tclk;
    busy_q = busy;
    if (eq_on && ({busy_i, tclk_i} !== ~{busy, tclk} ||
        id_i !== id || valid_i !== valid || acc_i !== acc ||
        err_i !== err || tcnt_i !== tcnt))
      eq_bad++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [30:0] id_mask(input logic [30:0] v,
                                          input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return v & m[30:0];
  endfunction

  task automatic tlu_txn(input logic [30:0] idv, input int n,
                         input int rdly);
    int t, k, r0, hi0, lo0, a0, bf0, e0, last;
    logic [30:0] exp_id;
    bit hold_ok;
    exp_id = id_mask(idv, n);
    r0 = rise_cnt; hi0 = bad_hi; lo0 = bad_lo;
    a0 = acc_cnt; bf0 = busy_fall; e0 = err_cnt;
    nbits = 5'(n);
    trig = 1'b1;
    t = 0;
    while (!busy && t < 20) begin cyc(); t++; end
    chk("busy_up", busy, 1);
    exp_cnt++;
    nbits = 5'($urandom);
    trig = 1'b0;
    k = 0; t = 0; last = rise_cnt;
    while (!valid && t < 1200) begin
      cyc(); t++;
      if (rise_cnt != last) begin
        last = rise_cnt;
        trig = (k < 31) ? idv[k] : 1'b0;
        k++;
      end
    end
    chk("valid_up", valid, 1);
    chk("trig_id", id, exp_id);
    chk("n_clocks", rise_cnt - r0, n);
    hold_ok = 1'b1;
    for (int i = 0; i < rdly; i++) begin
      cyc();
      if (!valid || !busy) hold_ok = 1'b0;
    end
    chk("hold_valid_busy", hold_ok, 1);
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    chk("valid_drop", valid, 0);
    chk("busy_drop", busy, 0);
    chk("id_held", id, exp_id);
    trig = 1'b0;
    repeat (12) cyc();
    chk("clk_total", rise_cnt - r0, n);
    chk("clk_shape", (bad_hi - hi0) + (bad_lo - lo0), 0);
    chk("acc_pulse", acc_cnt - a0, 1);
    chk("busy_once", busy_fall - bf0, 1);
    chk("no_err", err_cnt - e0, 0);
    chk("trig_cnt", tcnt, exp_cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, a0, b0, e0, v0, r0, last, k;
    logic [30:0] idv;
    rst_n = 1'b0; enable = 1'b1; nbits = '0; trig = 1'b0; ready = 1'b0;
    repeat (3) cyc();
    chk("rst_busy", busy, 0);
    chk("rst_clk", tclk, 0);
    chk("rst_busy_inv", busy_i, 1);
    chk("rst_clk_inv", tclk_i, 1);
    chk("rst_valid", valid, 0);
    chk("rst_id", id, 0);
    chk("rst_cnt", tcnt, 0);
    chk("rst_flags", {acc, err}, 0);
    rst_n = 1'b1;
    eq_on = 1'b1;
    repeat (5) cyc();

    tlu_txn(31'h1234, 15, 100);
    chk("first_cnt", tcnt, 1);

    a0 = acc_cnt; b0 = busy_cyc;
    trig = 1'b1; cyc(); trig = 1'b0;
    repeat (20) cyc();
    chk("glitch_acc", acc_cnt - a0, 0);
    chk("glitch_busy", busy_cyc - b0, 0);

    enable = 1'b0; trig = 1'b1;
    repeat (20) cyc();
    trig = 1'b0;
    repeat (5) cyc();
    enable = 1'b1;
    repeat (10) cyc();
    chk("dis_acc", acc_cnt - a0, 0);
    chk("dis_busy", busy_cyc - b0, 0);

    tlu_txn(31'h7fff_ffff, 0, 2);

    a0 = acc_cnt; e0 = err_cnt; v0 = vld_cyc;
    trig = 1'b1;
    t = 0;
    while (!busy && t < 20) begin cyc(); t++; end
    chk("to_busy", busy, 1);
    exp_cnt++;
    t = 0;
    while (!err && t < 1100) begin cyc(); t++; end
    chk("to_latency", t, 1024);
    chk("to_busy_rel", busy, 0);
    trig = 1'b0;
    repeat (12) cyc();
    chk("to_err_once", err_cnt - e0, 1);
    chk("to_no_valid", vld_cyc - v0, 0);
    chk("to_acc", acc_cnt - a0, 1);
    chk("to_cnt", tcnt, exp_cnt);

    for (int i = 0; i < 12; i++)
      tlu_txn(31'($urandom), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 6)));

    idv = 31'($urandom);
    nbits = 5'd15; trig = 1'b1;
    t = 0;
    while (!busy && t < 20) begin cyc(); t++; end
    trig = 1'b0;
    r0 = rise_cnt; last = rise_cnt; k = 0; t = 0;
    while (rise_cnt - r0 < 5 && t < 400) begin
      cyc(); t++;
      if (rise_cnt != last) begin
        last = rise_cnt;
        trig = idv[k];
        k++;
      end
    end
    chk("mid_pulse", tclk, 1);
    rst_n = 1'b0;
    cyc();
    chk("mrst_busy", busy, 0);
    chk("mrst_clk", tclk, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_cnt", tcnt, 0);
    rst_n = 1'b1; trig = 1'b0;
    exp_cnt = 0;
    repeat (10) cyc();

    tlu_txn(31'h0000_5a5a, 16, 1);
    chk("post_rst_cnt", tcnt, 1);
    for (int i = 0; i < 3; i++)
      tlu_txn(31'($urandom), int'($urandom_range(1, 31)),
              int'($urandom_range(0, 4)));

    chk("inv_twin", eq_bad, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
